spi_master_64bit: RTL and testbench

SPI_MASTER_64BIT -- requirements
Module: spi_master_64bit

---
 rtl/spi_master_64bit_pkg.sv | 20 ++
 rtl/spi_clk_gen.sv | 54 +++++
 rtl/spi_master_64bit.sv | 161 ++++++++++++++++
 tb/tb_spi_master_64bit.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_64bit_pkg.sv
// Shared constants and FSM encoding for the 64-bit SPI master and its peripheral models.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_master_64bit_pkg;

  localparam int FRAME_BITS = 64;
  localparam int WORD_BITS  = 32;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
  // Wide enough for any HALF_PERIOD / CS_SETUP / CS_IDLE up to 65535.
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI_CLK divider: while en=1 produces a mode-0 clock, HALF_PERIOD clk cycles low then high.
// Latency: rise/fall strobes are high on the clk cycle whose closing edge flips sclk.
// Backpressure: none; dropping en returns sclk low and restarts the phase at once.
// Ports: clk, rst_n (async active-low), en (run divider), sclk (serial clock),
//        rise/fall (one-cycle strobes announcing the next sclk edge).
module spi_clk_gen
  import spi_master_64bit_pkg::*;
#(
  parameter int HALF_PERIOD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             half_end;

  assign half_end = en && (cnt_q == CNT_W'(HALF_PERIOD - 1));

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      // Parked low with a fresh phase so the first half after enable is a full low half.
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (half_end) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;
  assign rise = half_end && !sclk_q;
  assign fall = half_end &&  sclk_q;

endmodule

// File: rtl/spi_master_64bit.sv
// 64-bit mode-0 SPI master: sends {operand2, operand1} MSB first, returns the received word.
// Latency: 1 + CS_SETUP + 129*HALF_PERIOD + CS_IDLE clk cycles from start to busy low.
// Backpressure: start is honoured only while busy=0; requests during a frame are dropped.
// Ports: clk, rst (async active-low), start, operand1/operand2 (low/high tx words),
//        busy, done (1-cycle end pulse), result (last rx word),
//        SPI_CLK, SPI_CS (active low), SPI_PICO (out), SPI_POCI (async in).
module spi_master_64bit
  import spi_master_64bit_pkg::*;
#(
  parameter int HALF_PERIOD = 8,
  parameter int CS_SETUP    = 8,
  parameter int CS_IDLE     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_BITS-1:0]  operand1,
  input  logic [WORD_BITS-1:0]  operand2,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] result,
  output logic                  SPI_CLK,
  output logic                  SPI_CS,
  output logic                  SPI_PICO,
  input  logic                  SPI_POCI
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic [FRAME_BITS-1:0] result_q, result_d;
  logic                  cs_q, cs_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  poci_meta_q, poci_meta_d;
  logic                  poci_sync_q, poci_sync_d;
  logic                  sclk_en, sclk_rise, sclk_fall;

  assign sclk_en = (state_q == ST_XFER);

  spi_clk_gen #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_clk_gen (
    .clk   (clk),
    .rst_n (rst),
    .en    (sclk_en),
    .sclk  (SPI_CLK),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    result_d    = result_q;
    cs_d        = cs_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    poci_meta_d = SPI_POCI;
    poci_sync_d = poci_meta_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_d    = {operand2, operand1};
          rx_d    = '0;
          cnt_d   = '0;
          bit_d   = '0;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = ST_XFER;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_XFER: begin
        if (sclk_rise) begin
          rx_d = {rx_q[FRAME_BITS-2:0], poci_sync_q};
        end
        if (sclk_fall) begin
          // PICO is tx_q[MSB], so shifting here is what moves data on falling edges.
          tx_d  = {tx_q[FRAME_BITS-2:0], 1'b0};
          bit_d = bit_q + 1'b1;
          if (bit_q == '1) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(HALF_PERIOD - 1)) begin
          cnt_d    = '0;
          cs_d     = 1'b1;
          tx_d     = '0;
          result_d = rx_q;
          done_d   = 1'b1;
          state_d  = ST_GAP;
        end else begin
          cnt_d    = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(CS_IDLE - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      result_q    <= '0;
      cs_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      poci_meta_q <= 1'b0;
      poci_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      result_q    <= result_d;
      cs_q        <= cs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      poci_meta_q <= poci_meta_d;
      poci_sync_q <= poci_sync_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign SPI_CS   = cs_q;
  assign SPI_PICO = tx_q[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_master_64bit.sv
`timescale 1ns/1ps
module tb_spi_master_64bit;
  import spi_master_64bit_pkg::*;

  localparam int CSS   = 8;
  localparam int CSI   = 8;
  localparam int N     = 3;
  localparam int LIMIT = 20000;
  localparam int HP_TAB [N] = '{8, 6, 100};

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    bit          fix_en;
    logic [63:0] fix_val;
    logic [63:0] exp_res;
  } vec_t;

  typedef struct packed {
    logic [31:0] rises_last;
    logic [63:0] last_word;
  } sl_t;

  typedef struct packed {
    logic [31:0] done_cnt;
    logic [31:0] res_bad;
    logic [31:0] busy_falls;
    logic [31:0] short_gaps;
  } mon_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [N-1:0] start_v = '0;
  logic [N-1:0] busy_v, done_v, sclk_v, cs_v, pico_v, poci_v;
  logic [31:0] op1_s [N];
  logic [31:0] op2_s [N];
  logic [63:0] result_s [N];
  bit          fix_en [N];
  logic [63:0] fix_val [N];
  vec_t        tbl [6];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_inst
    logic [63:0] sl_tx = '0;
    logic [63:0] sl_rx = '0;
    logic [63:0] sl_alu = '0;
    int          sl_rises = 0;
    logic        cs_p = 1'b1;
    logic        sc_p = 1'b0;
    sl_t         sl = '0;
    mon_t        mon = '0;
    logic [63:0] res_prev = '0;
    logic        busy_p = 1'b0;
    int          cs_run = 0;

    spi_master_64bit #(
      .HALF_PERIOD (HP_TAB[g]),
      .CS_SETUP    (CSS),
      .CS_IDLE     (CSI)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_v[g]),
      .operand1 (op1_s[g]),
      .operand2 (op2_s[g]),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .result   (result_s[g]),
      .SPI_CLK  (sclk_v[g]),
      .SPI_CS   (cs_v[g]),
      .SPI_PICO (pico_v[g]),
      .SPI_POCI (poci_v[g])
    );

    // Peripheral: loads its reply at CS fall, shifts out on SCLK fall, samples on SCLK rise,
    // and after a complete 64-bit frame its adder output becomes the next reply.
    always @(cs_v[g] or sclk_v[g]) begin
      if (cs_p === 1'b1 && cs_v[g] === 1'b0) begin
        sl_tx    = fix_en[g] ? fix_val[g] : sl_alu;
        sl_rx    = '0;
        sl_rises = 0;
      end else if (cs_p === 1'b0 && cs_v[g] === 1'b1) begin
        sl.rises_last = 32'(sl_rises);
        if (sl_rises == FRAME_BITS) begin
          sl.last_word = sl_rx;
          sl_alu = 64'(sl_rx[WORD_BITS-1:0]) + 64'(sl_rx[FRAME_BITS-1:WORD_BITS]);
        end
      end
      if (cs_v[g] === 1'b0) begin
        if (sc_p === 1'b0 && sclk_v[g] === 1'b1) begin
          sl_rx = {sl_rx[62:0], pico_v[g]};
          sl_rises++;
        end
        if (sc_p === 1'b1 && sclk_v[g] === 1'b0) sl_tx = {sl_tx[62:0], 1'b0};
      end
      cs_p = cs_v[g];
      sc_p = sclk_v[g];
    end
    assign poci_v[g] = sl_tx[63];

    always @(negedge clk) begin
      if (rst) begin
        if (done_v[g] === 1'b1) mon.done_cnt++;
        if (result_s[g] !== res_prev && done_v[g] !== 1'b1) mon.res_bad++;
        if (busy_p === 1'b1 && busy_v[g] === 1'b0) mon.busy_falls++;
        if (cs_v[g] === 1'b1) cs_run++;
        else begin
          if (cs_run > 0 && cs_run < CSI) mon.short_gaps++;
          cs_run = 0;
        end
      end
      res_prev = result_s[g];
      busy_p   = busy_v[g];
    end
  end

  function automatic mon_t get_mon(input int i);
    case (i)
      0:       return g_inst[0].mon;
      1:       return g_inst[1].mon;
      default: return g_inst[2].mon;
    endcase
  endfunction

  function automatic sl_t get_sl(input int i);
    case (i)
      0:       return g_inst[0].sl;
      1:       return g_inst[1].sl;
      default: return g_inst[2].sl;
    endcase
  endfunction

  function automatic int exp_len(input int hp);
    return 1 + CSS + 128 * hp + hp + CSI;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  task automatic chk_len(input string name, input int act, input int exp);
    checks++;
    if (act < exp - 1 || act > exp + 1) begin
      errors++;
      $display("FAIL %s: got %0d cycles, want %0d +/-1", name, act, exp);
    end
  endtask

  // pre=1: caller already raised start on the previous negedge.
  task automatic run_frame(input int i, input logic [31:0] a, input logic [31:0] b, input bit pre,
                           output logic [63:0] res, output int dw, output int len);
    int n;
    res = '0;
    dw  = 0;
    if (!pre) begin
      @(negedge clk);
      op1_s[i]   = a;
      op2_s[i]   = b;
      start_v[i] = 1'b1;
    end
    @(negedge clk);
    start_v[i] = 1'b0;
    chk($sformatf("accepted_%0d", i), 64'(busy_v[i]), 64'd1);
    len = 1;
    n   = 0;
    while (busy_v[i] === 1'b1 && n < LIMIT) begin
      @(negedge clk);
      len++;
      n++;
      if (done_v[i] === 1'b1) begin
        dw++;
        res = result_s[i];
      end
    end
    chk($sformatf("frame_timeout_%0d", i), 64'(n >= LIMIT), 64'd0);
  endtask

  task automatic check_frame(input string tag, input int i, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] exp,
                             input logic [63:0] res, input int dw, input int len);
    sl_t s;
    s = get_sl(i);
    chk({tag, "_result"}, res, exp);
    chk({tag, "_done_width"}, 64'(dw), 64'd1);
    chk({tag, "_pico_stream"}, s.last_word, {b, a});
    chk({tag, "_rises"}, 64'(s.rises_last), 64'd64);
    chk({tag, "_result_held"}, result_s[i], exp);
    chk_len({tag, "_frame_len"}, len, exp_len(HP_TAB[i]));
  endtask

  task automatic set_vec(input int k, input logic [31:0] a, input logic [31:0] b,
                         input bit fe, input logic [63:0] fv);
    tbl[k].op1     = a;
    tbl[k].op2     = b;
    tbl[k].fix_en  = fe;
    tbl[k].fix_val = fv;
    tbl[k].exp_res = '0;
  endtask

  initial begin
    logic [63:0] prev, res;
    logic [31:0] a, b;
    int          dw, len, n;
    mon_t        snap;

    for (int i = 0; i < N; i++) begin
      op1_s[i]   = '0;
      op2_s[i]   = '0;
      fix_en[i]  = 1'b0;
      fix_val[i] = '0;
    end

    // Reset values, checked before any clock edge.
    #1 rst = 1'b0;
    #1;
    chk("rst_cs",     64'(cs_v[0]),   64'd1);
    chk("rst_sclk",   64'(sclk_v[0]), 64'd0);
    chk("rst_pico",   64'(pico_v[0]), 64'd0);
    chk("rst_busy",   64'(busy_v[0]), 64'd0);
    chk("rst_done",   64'(done_v[0]), 64'd0);
    chk("rst_result", result_s[0],    64'd0);

    // Peripheral reply is the sum of the previous complete frame's operands,
    // or a forced pattern when fix_en is set.
    set_vec(0, 32'd3, 32'd5, 1'b0, 64'd0);
    set_vec(1, 32'h0123_4567, 32'hDEAD_BEEF, 1'b0, 64'd0);
    set_vec(2, $urandom, $urandom, 1'b1, 64'hA5A5_5A5A_F0F0_0F0F);
    set_vec(3, $urandom, $urandom, 1'b0, 64'd0);
    set_vec(4, $urandom, $urandom, 1'b1, {$urandom, $urandom});
    set_vec(5, $urandom, $urandom, 1'b0, 64'd0);
    prev = '0;
    for (int k = 0; k < 6; k++) begin
      tbl[k].exp_res = tbl[k].fix_en ? tbl[k].fix_val : prev;
      prev = 64'(tbl[k].op1) + 64'(tbl[k].op2);
    end

    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 6; k++) begin
      fix_en[0]  = tbl[k].fix_en;
      fix_val[0] = tbl[k].fix_val;
      run_frame(0, tbl[k].op1, tbl[k].op2, 1'b0, res, dw, len);
      check_frame($sformatf("vec%0d", k), 0, tbl[k].op1, tbl[k].op2, tbl[k].exp_res, res, dw, len);
    end
    fix_en[0] = 1'b0;

    // Reset mid-frame after 20 SCLK rises, asserted between clk edges.
    a = $urandom;
    b = $urandom;
    @(negedge clk);
    op1_s[0]   = a;
    op2_s[0]   = b;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (g_inst[0].sl_rises < 20 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("abort_rise_timeout", 64'(n >= LIMIT), 64'd0);
    snap = get_mon(0);
    #2 rst = 1'b0;
    #1;
    chk("abort_cs",     64'(cs_v[0]),   64'd1);
    chk("abort_sclk",   64'(sclk_v[0]), 64'd0);
    chk("abort_pico",   64'(pico_v[0]), 64'd0);
    chk("abort_busy",   64'(busy_v[0]), 64'd0);
    chk("abort_result", result_s[0],    64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_done", 64'(get_mon(0).done_cnt - snap.done_cnt), 64'd0);
    a = $urandom;
    b = $urandom;
    op1_s[0]   = a;
    op2_s[0]   = b;
    start_v[0] = 1'b1;
    rst        = 1'b1;
    run_frame(0, a, b, 1'b1, res, dw, len);
    check_frame("post_rst", 0, a, b, prev, res, dw, len);
    prev = 64'(a) + 64'(b);

    // start held high for three back-to-back frames.
    a = $urandom;
    b = $urandom;
    snap = get_mon(0);
    @(negedge clk);
    op1_s[0]   = a;
    op2_s[0]   = b;
    start_v[0] = 1'b1;
    n = 0;
    while (get_mon(0).done_cnt - snap.done_cnt < 3 && n < 4 * LIMIT) begin
      @(negedge clk);
      n++;
    end
    start_v[0] = 1'b0;
    while (busy_v[0] === 1'b1 && n < 4 * LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("hold_timeout",    64'(n >= 4 * LIMIT), 64'd0);
    chk("hold_done_count", 64'(get_mon(0).done_cnt - snap.done_cnt), 64'd3);
    chk("hold_busy_falls", 64'(get_mon(0).busy_falls - snap.busy_falls), 64'd3);
    chk("hold_short_gaps", 64'(get_mon(0).short_gaps - snap.short_gaps), 64'd0);
    chk("hold_result",     result_s[0], 64'(a) + 64'(b));

    // Loopback at the extreme half-periods.
    for (int i = 1; i < N; i++) begin
      a = $urandom;
      b = $urandom;
      run_frame(i, a, b, 1'b0, res, dw, len);
      check_frame($sformatf("hp%0d_f1", HP_TAB[i]), i, a, b, 64'd0, res, dw, len);
      prev = 64'(a) + 64'(b);
      a = $urandom;
      b = $urandom;
      run_frame(i, a, b, 1'b0, res, dw, len);
      check_frame($sformatf("hp%0d_f2", HP_TAB[i]), i, a, b, prev, res, dw, len);
    end

    for (int i = 0; i < N; i++) begin
      chk($sformatf("result_only_on_done_%0d", i), 64'(get_mon(i).res_bad), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
